// File: rtl/tlb_search_arbiter_if.sv
// Bundle of the three requester handshakes, the shared TLB search port and the
// registered response bus around tlb_search_arbiter.
interface tlb_search_arbiter_if #(
    parameter int TLBNUM = 16
);
    localparam int IDXW = $clog2(TLBNUM);

    logic            inst_req;
    logic [19:0]     inst_va;
    logic            inst_ready;
    logic            inst_cancel;
    logic            data_req;
    logic [19:0]     data_va;
    logic            data_ready;
    logic            srch_req;
    logic [19:0]     srch_va;
    logic            srch_ready;
    logic [9:0]      asid;

    logic [18:0]     s_vppn;
    logic            s_va_bit12;
    logic [9:0]      s_asid;
    logic            s_found;
    logic [IDXW-1:0] s_index;
    logic [19:0]     s_ppn;
    logic [5:0]      s_ps;
    logic [1:0]      s_plv;
    logic [1:0]      s_mat;
    logic            s_d;
    logic            s_v;

    logic            inst_rsp_valid;
    logic            data_rsp_valid;
    logic            srch_rsp_valid;
    logic            rsp_found;
    logic [IDXW-1:0] rsp_index;
    logic [19:0]     rsp_ppn;
    logic [5:0]      rsp_ps;
    logic [1:0]      rsp_plv;
    logic [1:0]      rsp_mat;
    logic            rsp_d;
    logic            rsp_v;

    // Arbiter side.
    modport master (
        input  inst_req, inst_va, inst_cancel, data_req, data_va, srch_req, srch_va, asid,
        input  s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
        output inst_ready, data_ready, srch_ready, s_vppn, s_va_bit12, s_asid,
        output inst_rsp_valid, data_rsp_valid, srch_rsp_valid,
        output rsp_found, rsp_index, rsp_ppn, rsp_ps, rsp_plv, rsp_mat, rsp_d, rsp_v
    );

    // Requester / TLB side.
    modport slave (
        output inst_req, inst_va, inst_cancel, data_req, data_va, srch_req, srch_va, asid,
        output s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
        input  inst_ready, data_ready, srch_ready, s_vppn, s_va_bit12, s_asid,
        input  inst_rsp_valid, data_rsp_valid, srch_rsp_valid,
        input  rsp_found, rsp_index, rsp_ppn, rsp_ps, rsp_plv, rsp_mat, rsp_d, rsp_v
    );
endinterface

// File: rtl/tlb_search_arbiter.sv
// Shares one TLB search port between inst fetch, load/store and TLBSRCH, returning
// the registered lookup one cycle later. Optional macro TLB_ARB_RR_EN: inst/data round-robin.
module tlb_search_arbiter #(
    parameter int TLBNUM       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   resetn,
    tlb_search_arbiter_if.master  bus
);
    localparam int IDXW = $clog2(TLBNUM);

    logic            inst_ok, inst_first;
    logic            srch_gnt, data_gnt, inst_gnt, any_gnt;
    logic [19:0]     sel_va;

    logic            inst_pend_q, data_vld_q, srch_vld_q;
    logic            rsp_found_q;
    logic [IDXW-1:0] rsp_index_q;
    logic [19:0]     rsp_ppn_q;
    logic [5:0]      rsp_ps_q;
    logic [1:0]      rsp_plv_q, rsp_mat_q;
    logic            rsp_d_q, rsp_v_q;

`ifdef TLB_ARB_RR_EN
    // rr_last_q=1: data won last time, so inst goes first now.
    logic rr_last_q, rr_last_d;

    always_comb begin
        rr_last_d = rr_last_q;
        if (data_gnt)      rr_last_d = 1'b1;
        else if (inst_gnt) rr_last_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rr_last_q <= 1'b0;
        else         rr_last_q <= rr_last_d;
    end

    assign inst_first = rr_last_q;
`else
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.inst_req || inst_gnt)
            starve_cnt_d = 4'd0;
        else if (starve_cnt_q != 4'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) starve_cnt_q <= 4'd0;
        else         starve_cnt_q <= starve_cnt_d;
    end

    assign inst_first = (starve_cnt_q == 4'(STARVE_LIMIT));
`endif

    // A cancelled inst request is never eligible, so data can take the slot.
    always_comb begin
        inst_ok  = bus.inst_req & ~bus.inst_cancel;
        srch_gnt = bus.srch_req;
        data_gnt = ~srch_gnt & bus.data_req & ~(inst_first & inst_ok);
        inst_gnt = ~srch_gnt & inst_ok & ~(bus.data_req & ~inst_first);
        any_gnt  = srch_gnt | data_gnt | inst_gnt;
        sel_va   = bus.inst_va;
        if (srch_gnt)      sel_va = bus.srch_va;
        else if (data_gnt) sel_va = bus.data_va;
    end

    assign bus.srch_ready = srch_gnt;
    assign bus.data_ready = data_gnt;
    assign bus.inst_ready = inst_gnt;
    assign bus.s_vppn     = sel_va[19:1];
    assign bus.s_va_bit12 = sel_va[0];
    assign bus.s_asid     = bus.asid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_pend_q <= 1'b0;
            data_vld_q  <= 1'b0;
            srch_vld_q  <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_index_q <= '0;
            rsp_ppn_q   <= '0;
            rsp_ps_q    <= '0;
            rsp_plv_q   <= '0;
            rsp_mat_q   <= '0;
            rsp_d_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
        end else begin
            inst_pend_q <= inst_gnt;
            data_vld_q  <= data_gnt;
            srch_vld_q  <= srch_gnt;
            if (any_gnt) begin
                rsp_found_q <= bus.s_found;
                rsp_index_q <= bus.s_index;
                rsp_ppn_q   <= bus.s_ppn;
                rsp_ps_q    <= bus.s_ps;
                rsp_plv_q   <= bus.s_plv;
                rsp_mat_q   <= bus.s_mat;
                rsp_d_q     <= bus.s_d;
                rsp_v_q     <= bus.s_v;
            end
        end
    end

    // A flush in the response cycle still kills the inst result already in flight.
    assign bus.inst_rsp_valid = inst_pend_q & ~bus.inst_cancel;
    assign bus.data_rsp_valid = data_vld_q;
    assign bus.srch_rsp_valid = srch_vld_q;
    assign bus.rsp_found      = rsp_found_q;
    assign bus.rsp_index      = rsp_index_q;
    assign bus.rsp_ppn        = rsp_ppn_q;
    assign bus.rsp_ps         = rsp_ps_q;
    assign bus.rsp_plv        = rsp_plv_q;
    assign bus.rsp_mat        = rsp_mat_q;
    assign bus.rsp_d          = rsp_d_q;
    assign bus.rsp_v          = rsp_v_q;
endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Directed bench for tlb_search_arbiter with a small combinational TLB model.
module tb_tlb_search_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tlb_search_arbiter_if #(.TLBNUM(16)) bus ();

    tlb_search_arbiter #(.TLBNUM(16), .STARVE_LIMIT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // TLB model: VA 1C008 hits idx 3 / ppn 0ABCD, anything else maps idx=va[3:0], ppn=~va.
    logic [19:0] tva;
    always_comb begin
        tva         = {bus.s_vppn, bus.s_va_bit12};
        bus.s_found = 1'b1;
        bus.s_index = tva[3:0];
        bus.s_ppn   = tva ^ 20'hFFFFF;
        bus.s_ps    = 6'd12;
        bus.s_plv   = tva[1:0];
        bus.s_mat   = 2'd1;
        bus.s_d     = 1'b1;
        bus.s_v     = 1'b1;
        if (tva == 20'h1C008) begin
            bus.s_index = 4'd3;
            bus.s_ppn   = 20'h0ABCD;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    function automatic logic [2:0] rdy();
        return {bus.srch_ready, bus.data_ready, bus.inst_ready};
    endfunction

    function automatic logic [2:0] vld();
        return {bus.srch_rsp_valid, bus.data_rsp_valid, bus.inst_rsp_valid};
    endfunction

    initial begin
        bus.inst_req = 0; bus.inst_va = 20'h0F00F; bus.inst_cancel = 0;
        bus.data_req = 0; bus.data_va = 20'h00F0F;
        bus.srch_req = 0; bus.srch_va = 20'h12345;
        bus.asid = 10'h2A5;
        #22 resetn = 1'b1;

        // Reset / idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_vld", 32'(vld()), 0);
            chk("rst_ppn", 32'(bus.rsp_ppn), 0);
            chk("rst_found_idx", 32'({bus.rsp_found, bus.rsp_index}), 0);
        end
        chk("idle_mux", 32'({bus.s_vppn, bus.s_va_bit12}), 32'h0F00F);
        chk("asid", 32'(bus.s_asid), 32'h2A5);
        nxt();

        // Single inst hit
        bus.inst_req = 1; bus.inst_va = 20'h1C008;
        @(negedge clk);
        chk("t2_rdy", 32'(rdy()), 3'b001);
        chk("t2_mux", 32'(bus.s_vppn), 32'h0E004);
        nxt();
        bus.inst_req = 0;
        @(negedge clk);
        chk("t2_vld", 32'(vld()), 3'b001);
        chk("t2_idx", 32'(bus.rsp_index), 3);
        chk("t2_ppn", 32'(bus.rsp_ppn), 32'h0ABCD);
        nxt();

        // All three at once
        bus.srch_req = 1; bus.data_req = 1; bus.inst_req = 1; bus.inst_va = 20'hAAAA6;
        @(negedge clk);
        chk("t3a_rdy", 32'(rdy()), 3'b100);
        chk("t3a_mux", 32'({bus.s_vppn, bus.s_va_bit12}), 32'h12345);
        nxt();
        bus.srch_req = 0;
        @(negedge clk);
        chk("t3b_rdy", 32'(rdy()), 3'b010);
        chk("t3b_vld", 32'(vld()), 3'b100);
        chk("t3b_rsp", 32'({bus.rsp_index, bus.rsp_ppn}), 32'h5EDCBA);
        nxt();
        bus.data_req = 0;
        @(negedge clk);
        chk("t3c_rdy", 32'(rdy()), 3'b001);
        chk("t3c_vld", 32'(vld()), 3'b010);
        chk("t3c_ppn", 32'(bus.rsp_ppn), 32'hFF0F0);
        nxt();
        bus.inst_req = 0;
        @(negedge clk);
        chk("t3d_rdy", 32'(rdy()), 0);
        chk("t3d_vld", 32'(vld()), 3'b001);
        chk("t3d_rsp", 32'({bus.rsp_index, bus.rsp_ppn}), 32'h655559);
        nxt();

`ifdef TLB_ARB_RR_EN
        // Round-robin alternation, data first
        for (int k = 0; k < 6; k++) begin
            bus.data_req = 1; bus.inst_req = 1;
            @(negedge clk);
            chk($sformatf("rr_k%0d", k), 32'(rdy()), (k % 2 == 0) ? 3'b010 : 3'b001);
            nxt();
        end
`else
        // Starvation promotion, twice to show the counter restarts from 0
        for (int k = 0; k < 12; k++) begin
            bus.data_req = 1;
            bus.inst_req = (k <= 4) || (k >= 6 && k <= 10);
            @(negedge clk);
            chk($sformatf("starve_k%0d", k), 32'(rdy()), (k == 4 || k == 10) ? 3'b001 : 3'b010);
            nxt();
        end
`endif
        bus.data_req = 0; bus.inst_req = 0;
        nxt();

        // Cancel kills in-flight inst response; data unaffected
        bus.inst_req = 1;
        @(negedge clk);
        chk("t5a_rdy", 32'(rdy()), 3'b001);
        nxt();
        bus.inst_cancel = 1; bus.data_req = 1;
        @(negedge clk);
        chk("t5b_rdy", 32'(rdy()), 3'b010);
        chk("t5b_vld", 32'(vld()), 0);
        nxt();
        bus.inst_cancel = 0; bus.data_req = 0; bus.inst_req = 0;
        @(negedge clk);
        chk("t5c_vld", 32'(vld()), 3'b010);
        chk("t5c_ppn", 32'(bus.rsp_ppn), 32'hFF0F0);
        nxt();
        @(negedge clk);
        chk("hold_vld", 32'(vld()), 0);
        chk("hold_ppn", 32'(bus.rsp_ppn), 32'hFF0F0);
        nxt();

        // Async reset drops a pending response
        bus.inst_req = 1; bus.inst_va = 20'h1C008;
        @(negedge clk);
        chk("rstmid_rdy", 32'(rdy()), 3'b001);
        nxt();
        bus.inst_req = 0;
        resetn = 1'b0;
        #1;
        chk("rstmid_vld", 32'(vld()), 0);
        chk("rstmid_ppn", 32'(bus.rsp_ppn), 0);
        #10 resetn = 1'b1;
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
